// File: rtl/nl_vc_fc_in.sv
// nl_vc_fc_in: receive side of per-VC credit flow control.
// Incoming flits land in one FIFO per virtual channel, each VC's head flit is
// offered to the router, and one credit is returned upstream (registered,
// one cycle later) for every flit the router dequeues.
// FIFO depth must match the upstream initial credit count.
// Optional build macro: NL_VC_FIFO_BYPASS_EN enables a zero-latency path from
// flit_in to head_flit when the target VC is empty.

package nl_vc_fc_pkg;
    localparam int NL_NUM_VCS     = 2;
    localparam int NL_VC_IDX_BITS = (NL_NUM_VCS > 1) ? $clog2(NL_NUM_VCS) : 1;
    localparam int NL_DATA_BITS   = 16;

    typedef logic [NL_VC_IDX_BITS-1:0] vc_index_t;

    typedef struct packed {
        logic [NL_NUM_VCS-1:0] vc_id;   // one-hot target VC
    } flit_ctrl_t;

    typedef struct packed {
        flit_ctrl_t              control;
        logic [NL_DATA_BITS-1:0] data;
    } flit_t;

    typedef struct packed {
        logic      credit_valid;
        vc_index_t credit;
    } chan_cntrl_t;
endpackage

// num_vcs must match nl_vc_fc_pkg::NL_NUM_VCS, since the flit's one-hot VC
// field is sized from the package.
module nl_vc_fc_in
    import nl_vc_fc_pkg::*;
#(
    parameter int num_vcs   = NL_NUM_VCS,
    parameter int buf_depth = 4,
    parameter int occ_bits  = $clog2(buf_depth + 1),
    parameter int ptr_bits  = (buf_depth > 1) ? $clog2(buf_depth) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  flit_t                             flit_in,
    input  logic                              flit_in_valid,
    input  logic [num_vcs-1:0]                pop,
    output flit_t [num_vcs-1:0]               head_flit,
    output logic [num_vcs-1:0]                head_valid,
    output chan_cntrl_t                       channel_cntrl_out,
    output logic [num_vcs-1:0][occ_bits-1:0]  vc_occupancy,
    output logic                              err_overflow,
    output logic                              err_underflow
);

    // Index of the lowest set bit; callers separately know whether any bit is set.
    function automatic vc_index_t low_bit_idx(input logic [num_vcs-1:0] vec);
        vc_index_t idx;
        idx = '0;
        for (int i = num_vcs - 1; i >= 0; i--) begin
            idx = vec[i] ? vc_index_t'(i) : idx;
        end
        return idx;
    endfunction

    // Pointer increment with explicit wrap so any depth works.
    function automatic logic [ptr_bits-1:0] next_ptr(input logic [ptr_bits-1:0] p);
        return (p == ptr_bits'(buf_depth - 1)) ? '0 : p + ptr_bits'(1);
    endfunction

    flit_t                             mem_r    [num_vcs][buf_depth];
    logic [ptr_bits-1:0]               rd_ptr_r [num_vcs];
    logic [ptr_bits-1:0]               wr_ptr_r [num_vcs];
    logic [num_vcs-1:0][occ_bits-1:0]  occ_r;
    chan_cntrl_t                       credit_r;
    logic                              ovf_r;
    logic                              unf_r;

    logic                push_any_s;
    vc_index_t           push_vc_s;
    logic                pop_any_s;
    vc_index_t           pop_vc_s;
    logic                pop_multi_s;
    logic                pop_ok_s;
    logic                push_ok_s;
    logic                ovf_s;
    logic                unf_s;
    logic [num_vcs-1:0]  empty_s;
    logic [num_vcs-1:0]  full_s;
    logic [num_vcs-1:0]  bypass_s;
    logic [num_vcs-1:0]  consume_s;
    logic [num_vcs-1:0]  rd_adv_s;
    logic [num_vcs-1:0]  wr_en_s;

    // Decide which push/pop is serviced this cycle and which error flags fire.
    always_comb begin
        push_any_s  = flit_in_valid & (|flit_in.control.vc_id);
        push_vc_s   = low_bit_idx(flit_in.control.vc_id);
        pop_any_s   = |pop;
        pop_vc_s    = low_bit_idx(pop);
        pop_multi_s = (32'($countones(pop)) > 32'd1);
        empty_s     = '0;
        full_s      = '0;
        bypass_s    = '0;
        consume_s   = '0;
        rd_adv_s    = '0;
        wr_en_s     = '0;
        for (int v = 0; v < num_vcs; v++) begin
            empty_s[v] = (occ_r[v] == '0);
            full_s[v]  = (occ_r[v] == occ_bits'(buf_depth));
`ifdef NL_VC_FIFO_BYPASS_EN
            bypass_s[v] = push_any_s && (push_vc_s == vc_index_t'(v)) && empty_s[v];
`else
            bypass_s[v] = 1'b0;
`endif
        end
        // A pop is serviced if its lowest set VC holds a flit (or one is bypassing in).
        pop_ok_s  = pop_any_s && (!empty_s[pop_vc_s] || bypass_s[pop_vc_s]);
        // A full VC still accepts a push when the same VC is popped this cycle.
        push_ok_s = push_any_s && (!full_s[push_vc_s] || (pop_ok_s && (pop_vc_s == push_vc_s)));
        for (int v = 0; v < num_vcs; v++) begin
            consume_s[v] = pop_ok_s && (pop_vc_s == vc_index_t'(v)) && bypass_s[v];
            rd_adv_s[v]  = pop_ok_s && (pop_vc_s == vc_index_t'(v)) && !bypass_s[v];
            wr_en_s[v]   = push_ok_s && (push_vc_s == vc_index_t'(v)) && !consume_s[v];
        end
        ovf_s = push_any_s && !push_ok_s;
        unf_s = pop_multi_s || (pop_any_s && !pop_ok_s);
    end

    // Present each VC's head flit; the bypass build forwards flit_in into an empty VC.
    always_comb begin
        head_flit  = '0;
        head_valid = '0;
        for (int v = 0; v < num_vcs; v++) begin
            if (bypass_s[v]) begin
                head_flit[v]  = flit_in;
                head_valid[v] = 1'b1;
            end else begin
                head_flit[v]  = mem_r[v][rd_ptr_r[v]];
                head_valid[v] = !empty_s[v];
            end
        end
    end

    // Flit storage: write the accepted flit at the VC's write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < num_vcs; v++) begin
                for (int d = 0; d < buf_depth; d++) begin
                    mem_r[v][d] <= '0;
                end
            end
        end else begin
            for (int v = 0; v < num_vcs; v++) begin
                if (wr_en_s[v]) begin
                    mem_r[v][wr_ptr_r[v]] <= flit_in;
                end
            end
        end
    end

    // Per-VC read/write pointers and occupancy counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < num_vcs; v++) begin
                rd_ptr_r[v] <= '0;
                wr_ptr_r[v] <= '0;
            end
            occ_r <= '0;
        end else begin
            for (int v = 0; v < num_vcs; v++) begin
                if (wr_en_s[v]) begin
                    wr_ptr_r[v] <= next_ptr(wr_ptr_r[v]);
                end
                if (rd_adv_s[v]) begin
                    rd_ptr_r[v] <= next_ptr(rd_ptr_r[v]);
                end
                case ({wr_en_s[v], rd_adv_s[v]})
                    2'b10:   occ_r[v] <= occ_r[v] + occ_bits'(1);
                    2'b01:   occ_r[v] <= occ_r[v] - occ_bits'(1);
                    default: occ_r[v] <= occ_r[v];
                endcase
            end
        end
    end

    // Registered credit return and one-cycle error pulses; credit id holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_r <= '0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            credit_r.credit_valid <= pop_ok_s;
            if (pop_ok_s) begin
                credit_r.credit <= pop_vc_s;
            end
            ovf_r <= ovf_s;
            unf_r <= unf_s;
        end
    end

    assign vc_occupancy      = occ_r;
    assign channel_cntrl_out = credit_r;
    assign err_overflow      = ovf_r;
    assign err_underflow     = unf_r;

endmodule

// File: tb/tb_nl_vc_fc_in.sv
// Scoreboard bench for nl_vc_fc_in: directed scenarios followed by random
// push/pop traffic, checked against a queue-based reference model.
module tb_nl_vc_fc_in;
    import nl_vc_fc_pkg::*;

    localparam int NV = 2;
    localparam int BD = 4;
    localparam int OB = $clog2(BD + 1);
`ifdef NL_VC_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    flit_t                     flit_in = '0;
    logic                      flit_in_valid = 1'b0;
    logic [NV-1:0]             pop = '0;
    flit_t [NV-1:0]            head_flit;
    logic [NV-1:0]             head_valid;
    chan_cntrl_t               channel_cntrl_out;
    logic [NV-1:0][OB-1:0]     vc_occupancy;
    logic                      err_overflow;
    logic                      err_underflow;

    nl_vc_fc_in #(.num_vcs(NV), .buf_depth(BD)) dut (
        .clk               (clk),
        .rst               (rst),
        .flit_in           (flit_in),
        .flit_in_valid     (flit_in_valid),
        .pop               (pop),
        .head_flit         (head_flit),
        .head_valid        (head_valid),
        .channel_cntrl_out (channel_cntrl_out),
        .vc_occupancy      (vc_occupancy),
        .err_overflow      (err_overflow),
        .err_underflow     (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit cv;
        bit ovf;
        bit unf;
    } rec_t;

    int    n_checks = 0;
    int    n_errors = 0;
    rec_t  rec_q[$];
    int    credit_q[$];
    int    last_credit = 0;
    flit_t mq [NV][$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: after each edge, compare registered outputs with the oldest expectation.
    initial begin
        rec_t r;
        int   e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && rec_q.size() > 0) begin
                r = rec_q.pop_front();
                check("credit_valid", int'(channel_cntrl_out.credit_valid), int'(r.cv));
                check("err_overflow", int'(err_overflow), int'(r.ovf));
                check("err_underflow", int'(err_underflow), int'(r.unf));
                if (channel_cntrl_out.credit_valid) begin
                    if (credit_q.size() == 0) begin
                        check("credit_unexpected", 1, 0);
                    end else begin
                        e = credit_q.pop_front();
                        check("credit_vc", int'(channel_cntrl_out.credit), e);
                        last_credit = e;
                    end
                end else begin
                    check("credit_hold", int'(channel_cntrl_out.credit), last_credit);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        flit_in_valid = 1'b0;
        flit_in = '0;
        pop = '0;
        for (int v = 0; v < NV; v++) mq[v].delete();
        rec_q.delete();
        credit_q.delete();
        last_credit = 0;
        repeat (2) @(negedge clk);
        for (int v = 0; v < NV; v++) begin
            check("rst_occupancy", int'(vc_occupancy[v]), 0);
        end
        check("rst_head_valid", int'(head_valid), 0);
        check("rst_credit_valid", int'(channel_cntrl_out.credit_valid), 0);
        check("rst_credit", int'(channel_cntrl_out.credit), 0);
        check("rst_err_overflow", int'(err_overflow), 0);
        check("rst_err_underflow", int'(err_underflow), 0);
    endtask

    // One cycle of stimulus: check state, drive inputs, advance the model.
    task automatic step(input bit v_in, input int vc, input logic [15:0] data, input logic [NV-1:0] p);
        flit_t fin;
        bit    byp [NV];
        int    sel;
        bit    multi, pop_ok, accept, consumed, hv;
        @(negedge clk);
        for (int v = 0; v < NV; v++) begin
            check("occupancy", int'(vc_occupancy[v]), mq[v].size());
        end
        fin = '0;
        fin.control.vc_id[vc] = 1'b1;
        fin.data = data;
        rst = 1'b0;
        flit_in = fin;
        flit_in_valid = v_in;
        pop = p;
        #1;
        for (int v = 0; v < NV; v++) begin
            byp[v] = BYP && v_in && (vc == v) && (mq[v].size() == 0);
            hv = (mq[v].size() != 0) || byp[v];
            check("head_valid", int'(head_valid[v]), int'(hv));
            if (hv) begin
                check("head_flit", int'(head_flit[v]), (mq[v].size() != 0) ? int'(mq[v][0]) : int'(fin));
            end
        end
        sel = -1;
        for (int i = NV - 1; i >= 0; i--) if (p[i]) sel = i;
        multi    = ($countones(p) > 1);
        pop_ok   = (sel >= 0) && ((mq[sel].size() > 0) || byp[sel]);
        accept   = v_in && ((mq[vc].size() < BD) || (pop_ok && sel == vc));
        consumed = pop_ok && byp[sel];
        if (pop_ok && !consumed) void'(mq[sel].pop_front());
        if (accept && !consumed) mq[vc].push_back(fin);
        if (pop_ok) credit_q.push_back(sel);
        rec_q.push_back('{cv: pop_ok, ovf: v_in && !accept, unf: multi || (sel >= 0 && !pop_ok)});
    endtask

    initial begin
        int r;
        do_reset();
        // Fill VC0 with A..D, then offer a fifth flit with no pop.
        for (int i = 0; i < 4; i++) step(1'b1, 0, 16'hA0 + 16'(i), 2'b00);
        step(1'b1, 0, 16'h00E0, 2'b00);
        // Drain VC0 in order, pointers wrap.
        for (int i = 0; i < 4; i++) step(1'b0, 0, 16'h0000, 2'b01);
        // VC1 at occupancy 2, then simultaneous push and pop.
        step(1'b1, 1, 16'h0B10, 2'b00);
        step(1'b1, 1, 16'h0B11, 2'b00);
        step(1'b1, 1, 16'h0B12, 2'b10);
        step(1'b0, 0, 16'h0000, 2'b10);
        step(1'b0, 0, 16'h0000, 2'b00);
        // Push to full VC with same-cycle pop of that VC.
        for (int i = 0; i < 3; i++) step(1'b1, 1, 16'h0C00 + 16'(i), 2'b00);
        step(1'b1, 1, 16'h0CFF, 2'b10);
        // Drain VC1 down to one flit, put one in VC0, then pop both at once.
        for (int i = 0; i < 3; i++) step(1'b0, 0, 16'h0000, 2'b10);
        step(1'b1, 0, 16'h0D00, 2'b00);
        step(1'b0, 0, 16'h0000, 2'b11);
        step(1'b0, 0, 16'h0000, 2'b10);
        step(1'b0, 0, 16'h0000, 2'b10);
        step(1'b0, 0, 16'h0000, 2'b01);
        // Push to empty VC0 with same-cycle pop.
        step(1'b1, 0, 16'h0F00, 2'b01);
        step(1'b0, 0, 16'h0000, 2'b00);
        step(1'b0, 0, 16'h0000, 2'b00);
        // Mid-operation reset with data held.
        step(1'b1, 0, 16'h0F01, 2'b00);
        step(1'b1, 1, 16'h0F02, 2'b00);
        do_reset();
        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            logic [NV-1:0] p;
            r = int'($urandom_range(0, 99));
            if (r < 15) p = '0;
            else if (r < 85) begin
                p = '0;
                p[$urandom_range(0, NV - 1)] = 1'b1;
            end else p = NV'($urandom_range(0, (1 << NV) - 1));
            if ($urandom_range(0, 299) == 0) do_reset();
            step(($urandom_range(0, 99) < 60), int'($urandom_range(0, NV - 1)), 16'($urandom), p);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 0, 16'h0000, 2'b00);
        @(negedge clk);
        check("credit_q_drained", credit_q.size(), 0);
        check("rec_q_drained", rec_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/nl_vc_fc_in.md
Name: nl_vc_fc_in

Overview:
Receive-side partner of the per-VC credit flow-control output block.
- Accepts flits from the link into per-VC FIFOs.
- Presents each VC's head flit to the router.
- Returns one credit upstream for every flit the router dequeues.
- FIFO depth equals the upstream initial credit count, so a correctly behaving sender never overflows it.

Parameters:
num_vcs, 2, number of virtual channels
buf_depth, 4, flits per VC FIFO; must equal the upstream init_credits
occ_bits, clogb2(buf_depth+1), occupancy counter width (holds 0..buf_depth)
ptr_bits, clogb2(buf_depth), read/write pointer width

Ports:
clk  input  1  clock
rst  input  1  reset
flit_in  input  flit_t  flit from link; target VC is flit_in.control.vc_id (one-hot)
flit_in_valid  input  1  flit_in is valid this cycle
pop  input  num_vcs  router dequeue request; zero or one-hot
head_flit  output  num_vcs x flit_t  head flit of each VC
head_valid  output  num_vcs  head_flit[v] is valid (VC v non-empty)
channel_cntrl_out  output  chan_cntrl_t  credit return: .credit_valid, .credit (vc_index_t)
vc_occupancy  output  num_vcs x occ_bits  flits currently held per VC
err_overflow  output  1  one-cycle pulse: flit arrived at a full VC
err_underflow  output  1  one-cycle pulse: pop of an empty VC, or pop not one-hot

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - All FIFOs empty; read/write pointers 0.
  - vc_occupancy all 0; head_valid all 0.
  - channel_cntrl_out.credit_valid 0, .credit 0.
  - err_overflow 0, err_underflow 0.
- Storage: num_vcs x buf_depth flit register array.
  - Per-VC read pointer, write pointer and occupancy counter.
  - Pointers wrap from buf_depth-1 to 0 by explicit compare, so non-power-of-2 depth is legal.
- Push: flit_in_valid=1 writes flit_in into VC v = oh2bin(flit_in.control.vc_id) at wr_ptr[v]; wr_ptr[v] advances.
- Pop: pop[v]=1 with occupancy[v]>0 advances rd_ptr[v].
  - head_flit[v] is combinational from storage at rd_ptr[v].
  - head_valid[v] = (occupancy[v] != 0).
- Occupancy update per VC:
  - push only: +1
  - pop only: -1
  - push and pop on the same VC in the same cycle: unchanged
- Push latency: flit accepted in cycle N gives head_valid=1 in cycle N+1 (base build).
- Boundary: push to a full VC.
  - With a same-cycle pop of that VC: push accepted; occupancy stays at buf_depth.
  - Without one: flit dropped, no state change, err_overflow=1 for one cycle.
- Boundary: pop of an empty VC is ignored; no credit returned; err_underflow=1 for one cycle.
- Boundary: pop with more than one bit set.
  - Only the lowest-index set bit is serviced.
  - err_underflow=1 for one cycle.
- Credit return is registered with latency 1: a serviced pop of VC v in cycle N gives, in cycle N+1:
  - channel_cntrl_out.credit_valid=1
  - channel_cntrl_out.credit=v
- At most one credit is returned per cycle; pop is at most one-hot, so there is no credit queue.
- When no serviced pop occurs, credit_valid=0 and credit holds its last value.
- Reset mid-operation: all contents are discarded and no credits are returned for them. The upstream counter must be reset in the same cycle.

Optional Feature:
NL_VC_FIFO_BYPASS_EN
- Defined: when VC v is empty and flit_in_valid targets v:
  - head_valid[v]=1 and head_flit[v]=flit_in in the same cycle (zero-latency bypass).
  - A same-cycle pop[v] consumes the flit without writing storage; occupancy stays 0 and the credit is returned in the next cycle as usual.
  - If not popped, the flit is written normally.
- Undefined: head_valid rises one cycle after the push. head_flit never depends combinationally on flit_in.

Test Plan:
1. Reset, then push VC0 flits A,B,C,D (num_vcs=2, buf_depth=4) -> vc_occupancy[0]=4, head_flit[0]=A, no credits, no errors.
2. From state 1, push a fifth flit E to VC0 with pop=0 -> E dropped, err_overflow pulses 1 cycle, occupancy stays 4.
3. From state 1, pop[0]=1 for 4 consecutive cycles -> head order A,B,C,D; credit_valid=1 with credit=0 in each following cycle; occupancy ends 0; pointers wrapped to 0.
4. Push VC1 and pop VC1 in the same cycle with occupancy[1]=2 -> occupancy stays 2; one credit for VC1 next cycle; FIFO order preserved.
5. pop=2'b11 with both VCs holding 1 flit -> only VC0 dequeued, credit=0 next cycle, err_underflow pulses; then pop[1] on empty VC1 after draining -> no credit, err_underflow pulses.
6. With NL_VC_FIFO_BYPASS_EN, push to empty VC0 and pop[0] in the same cycle -> head_valid[0]=1 in that cycle, occupancy stays 0, credit=0 next cycle. Without the macro -> head_valid[0] rises in cycle N+1.
